// File: rtl/handshake_pkg.sv
// Shared constants and helpers for the handshake buffer family.
package handshake_pkg;

    localparam int unsigned DATA_W_DEFAULT = 8;

    // Modulo-depth pointer increment, wrapping at depth-1.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/handshake_fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write, asynchronous read, async clear.
module handshake_fifo_mem
    import handshake_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned DEPTH  = 2,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/handshake_fifo.sv
// Elastic valid/ready buffer; ready_s, valid_d and data_d are driven from registers only.
module handshake_fifo
    import handshake_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned DEPTH  = 2,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              valid_s,
    input  logic [DATA_W-1:0] data_s,
    output logic              ready_s,
    output logic              valid_d,
    output logic [DATA_W-1:0] data_d,
    input  logic              ready_d,
    output logic [CW-1:0]     count
);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_nxt;
    logic          push;
    logic          pop;

    assign push = valid_s && ready_s;
    assign pop  = valid_d && ready_d;

    // Occupancy update; simultaneous push and pop cancel out.
    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count - CW'(1);
        end
    end

    // Flags are registered from the next occupancy so they never see ready_d/valid_s combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ready_s <= 1'b1;
            valid_d <= 1'b0;
        end else if (flush) begin
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ready_s <= 1'b1;
            valid_d <= 1'b0;
        end else begin
            count   <= count_nxt;
            ready_s <= (count_nxt != CW'(DEPTH));
            valid_d <= (count_nxt != CW'(0));
            if (push) begin
                wr_ptr <= AW'(ptr_inc(32'(wr_ptr), DEPTH));
            end
            if (pop) begin
                rd_ptr <= AW'(ptr_inc(32'(rd_ptr), DEPTH));
            end
        end
    end

    handshake_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push && !flush),
        .waddr (wr_ptr),
        .wdata (data_s),
        .raddr (rd_ptr),
        .rdata (data_d)
    );

endmodule

// File: tb/tb_handshake_fifo.sv
// Scoreboard bench for handshake_fifo (DEPTH=4, DATA_W=8).
module tb_handshake_fifo;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              valid_s;
    logic [DATA_W-1:0] data_s;
    logic              ready_s;
    logic              valid_d;
    logic [DATA_W-1:0] data_d;
    logic              ready_d;
    logic [CW-1:0]     count;

    int total = 0;
    int bad   = 0;
    int pop_cnt = 0;
    logic [DATA_W-1:0] exp_q[$];

    handshake_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .valid_s (valid_s),
        .data_s  (data_s),
        .ready_s (ready_s),
        .valid_d (valid_d),
        .data_d  (data_d),
        .ready_d (ready_d),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input int max_cycles);
        int n = 0;
        while (count != '0 && n < max_cycles) begin
            tick();
            n++;
        end
        chk("drain_count", 32'(count), 32'd0);
    endtask

    // Monitor: sample mid-cycle, pop expected words on each destination transfer, record accepted source words.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            total++;
            if (count > CW'(DEPTH)) begin
                bad++;
                $display("FAIL count_range: got %0d expected <= %0d", count, DEPTH);
            end
            if (flush) begin
                exp_q.delete();
            end else begin
                if (valid_d && ready_d) begin
                    pop_cnt++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_pop: got 0x%0h expected no output", data_d);
                    end else begin
                        chk("data_d", 32'(data_d), 32'(exp_q.pop_front()));
                    end
                end
                if (valid_s && ready_s) begin
                    exp_q.push_back(data_s);
                end
            end
        end
    end

    initial begin
        int p0;
        rst = 1'b1; flush = 1'b0; valid_s = 1'b0; data_s = '0; ready_d = 1'b0;
        #1;
        chk("rst_ready_s", 32'(ready_s), 32'd1);
        chk("rst_valid_d", 32'(valid_d), 32'd0);
        chk("rst_data_d",  32'(data_d),  32'd0);
        chk("rst_count",   32'(count),   32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Single word, one-cycle latency.
        valid_s = 1'b1; data_s = 8'h11; ready_d = 1'b1;
        chk("t1_ready_s", 32'(ready_s), 32'd1);
        tick();
        valid_s = 1'b0;
        chk("t1_valid_d", 32'(valid_d), 32'd1);
        chk("t1_data_d",  32'(data_d),  32'h11);
        chk("t1_count",   32'(count),   32'd1);
        tick();
        chk("t1_count_after", 32'(count), 32'd0);
        chk("t1_valid_after", 32'(valid_d), 32'd0);

        // Streaming at full rate.
        p0 = pop_cnt;
        for (int i = 1; i <= 16; i++) begin
            valid_s = 1'b1; data_s = DATA_W'(i);
            if (ready_s !== 1'b1 || count > CW'(1)) begin
                chk("t2_stream_flags", {30'd0, ready_s, (count <= CW'(1))}, 32'd3);
            end
            tick();
        end
        valid_s = 1'b0;
        tick();
        chk("t2_pops", 32'(pop_cnt - p0), 32'd16);
        chk("t2_count", 32'(count), 32'd0);

        // Fill to full, back-pressure the fifth word, release one slot.
        ready_d = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid_s = 1'b1; data_s = 8'hA0 + DATA_W'(i);
            tick();
        end
        chk("t3_full_count", 32'(count), 32'd4);
        chk("t3_full_ready", 32'(ready_s), 32'd0);
        data_s = 8'hA4;
        tick();
        chk("t3_held_count", 32'(count), 32'd4);
        ready_d = 1'b1;
        tick();
        ready_d = 1'b0;
        chk("t3_after_pop_count", 32'(count), 32'd3);
        chk("t3_after_pop_ready", 32'(ready_s), 32'd1);
        chk("t3_head", 32'(data_d), 32'hA1);
        tick();
        valid_s = 1'b0;
        chk("t3_a4_count", 32'(count), 32'd4);
        ready_d = 1'b1;
        wait_empty(20);

        // Stall: output held stable.
        ready_d = 1'b0;
        valid_s = 1'b1; data_s = 8'h5A;
        tick();
        valid_s = 1'b0; data_s = 8'h00;
        for (int i = 0; i < 10; i++) begin
            if (valid_d !== 1'b1 || data_d !== 8'h5A) begin
                chk("t4_stall", {23'd0, valid_d, data_d}, {23'd0, 1'b1, 8'h5A});
            end
            tick();
        end
        chk("t4_stall_valid", 32'(valid_d), 32'd1);
        chk("t4_stall_data",  32'(data_d),  32'h5A);
        ready_d = 1'b1;
        wait_empty(10);

        // Pointer wrap with irregular destination back-pressure.
        p0 = pop_cnt;
        for (int i = 0; i < 3 * int'(DEPTH); i++) begin
            int n = 0;
            logic acc;
            valid_s = 1'b1; data_s = 8'hC0 + DATA_W'(i);
            do begin
                ready_d = 1'($urandom_range(0, 1));
                acc = ready_s;
                tick();
                n++;
            end while (!acc && n < 100);
            if (!acc) chk("t5_accept_timeout", 32'd0, 32'd1);
        end
        valid_s = 1'b0;
        ready_d = 1'b1;
        wait_empty(20);
        chk("t5_pops", 32'(pop_cnt - p0), 32'(3 * DEPTH));

        // Flush with simultaneous push and pop.
        ready_d = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_s = 1'b1; data_s = 8'hD0 + DATA_W'(i);
            tick();
        end
        chk("t6_pre_count", 32'(count), 32'd3);
        flush = 1'b1; valid_s = 1'b1; data_s = 8'hEE; ready_d = 1'b1;
        tick();
        flush = 1'b0; valid_s = 1'b0;
        chk("t6_count",   32'(count),   32'd0);
        chk("t6_valid_d", 32'(valid_d), 32'd0);
        chk("t6_ready_s", 32'(ready_s), 32'd1);
        tick(); tick();
        chk("t6_still_empty", 32'(valid_d), 32'd0);

        // Asynchronous reset mid-stream.
        ready_d = 1'b0;
        valid_s = 1'b1; data_s = 8'h31; tick();
        data_s = 8'h32; tick();
        valid_s = 1'b0;
        chk("t7_pre_count", 32'(count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("t7_rst_ready_s", 32'(ready_s), 32'd1);
        chk("t7_rst_valid_d", 32'(valid_d), 32'd0);
        chk("t7_rst_data_d",  32'(data_d),  32'd0);
        chk("t7_rst_count",   32'(count),   32'd0);
        tick();
        rst = 1'b0;
        tick();
        valid_s = 1'b1; data_s = 8'h77; ready_d = 1'b1;
        tick();
        valid_s = 1'b0;
        chk("t7_new_valid", 32'(valid_d), 32'd1);
        chk("t7_new_data",  32'(data_d),  32'h77);
        tick();
        chk("t7_final_count", 32'(count), 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
